// File: rtl/guess_game_pkg.sv
// guess_game_pkg: shared operand width, attempt limit and state encoding for the guessing game
package guess_game_pkg;
   localparam int W = 3;
   localparam int MAX_TRIES_DEF = 4;
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_CHECK = 3'd2,
      ST_WIN   = 3'd3,
      ST_LOSE  = 3'd4
   } state_t;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on the 0->1 transition of an already synchronized level
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic rise
);
   logic prev;
   // remember the previous level so a held input fires only once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= 1'b0;
      else prev <= in;
   end
   assign rise = in & ~prev;
endmodule

// File: rtl/three_bit_comparator.sv
// three_bit_comparator: unsigned magnitude compare of guess (A) against secret (B)
module three_bit_comparator
   import guess_game_pkg::*;
(
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         GT,
   output logic         LT,
   output logic         EQ
);
   assign GT = A > B;
   assign LT = A < B;
   assign EQ = A == B;
endmodule

// File: rtl/guess_game_controller.sv
// guess_game_controller: sequences a number-guessing game around an external comparator
module guess_game_controller
   import guess_game_pkg::*;
#(
   parameter int MAX_TRIES = MAX_TRIES_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         START,
   input  logic         SUBMIT,
   input  logic [W-1:0] SW,
   input  logic         GT,
   input  logic         LT,
   input  logic         EQ,
   output logic [W-1:0] GUESS,
   output logic [W-1:0] SECRET,
   output logic [W-1:0] TRIES,
   output logic         HIGH,
   output logic         LOW,
   output logic         WIN,
   output logic         LOSE,
   output logic         ERR
);
   localparam logic [W-1:0] MAX_T = W'(MAX_TRIES);
   state_t state;
   logic [W-1:0] seed;
   logic start_rise, submit_rise;
   rise_detect u_start (.clk(clk), .rst_n(rst_n), .in(START), .rise(start_rise));
   rise_detect u_submit (.clk(clk), .rst_n(rst_n), .in(SUBMIT), .rise(submit_rise));
   // free-running seed plus game FSM; CHECK lets the comparator settle on the registered operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         seed   <= '0;
         GUESS  <= '0;
         SECRET <= '0;
         TRIES  <= '0;
         HIGH   <= 1'b0;
         LOW    <= 1'b0;
         WIN    <= 1'b0;
         LOSE   <= 1'b0;
         ERR    <= 1'b0;
      end else begin
         seed <= seed + 1'b1;
         if (start_rise && state != ST_CHECK) begin
            SECRET <= seed;
            TRIES  <= '0;
            HIGH   <= 1'b0;
            LOW    <= 1'b0;
            WIN    <= 1'b0;
            LOSE   <= 1'b0;
            ERR    <= 1'b0;
            state  <= ST_PLAY;
         end else if (state == ST_PLAY && submit_rise) begin
            GUESS <= SW;
            TRIES <= TRIES + 1'b1;
            state <= ST_CHECK;
         end else if (state == ST_CHECK) begin
            if (!$onehot({GT, LT, EQ})) begin
               ERR   <= 1'b1;
               LOSE  <= 1'b1;
               HIGH  <= 1'b0;
               LOW   <= 1'b0;
               state <= ST_LOSE;
            end else if (EQ) begin
               WIN   <= 1'b1;
               HIGH  <= 1'b0;
               LOW   <= 1'b0;
               state <= ST_WIN;
            end else begin
               HIGH <= GT;
               LOW  <= LT;
               if (TRIES == MAX_T) begin
                  LOSE  <= 1'b1;
                  state <= ST_LOSE;
               end else begin
                  state <= ST_PLAY;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_guess_game_controller.sv
// tb_guess_game_controller: directed and randomized games checked against a rule-level model
module tb_guess_game_controller;
   localparam int MT = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic START = 1'b0;
   logic SUBMIT = 1'b0;
   logic bad = 1'b0;
   logic [2:0] SW = 3'd0;
   logic [2:0] GUESS, SECRET, TRIES;
   logic HIGH, LOW, WIN, LOSE, ERR;
   logic c_gt, c_lt, c_eq, GT, LT, EQ;
   int m_seed, m_guess, m_secret, m_tries;
   bit m_on, m_high, m_low, m_win, m_lose, m_err;
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   three_bit_comparator cmp (.A(GUESS), .B(SECRET), .GT(c_gt), .LT(c_lt), .EQ(c_eq));
   assign GT = c_gt & ~bad;
   assign LT = c_lt & ~bad;
   assign EQ = c_eq & ~bad;

   guess_game_controller #(.MAX_TRIES(MT)) dut (
      .clk(clk), .rst_n(rst_n), .START(START), .SUBMIT(SUBMIT), .SW(SW),
      .GT(GT), .LT(LT), .EQ(EQ), .GUESS(GUESS), .SECRET(SECRET), .TRIES(TRIES),
      .HIGH(HIGH), .LOW(LOW), .WIN(WIN), .LOSE(LOSE), .ERR(ERR)
   );

   // reference seed: counts clock edges since reset release, modulo 8
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_seed <= 0;
      else m_seed <= (m_seed + 1) % 8;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " guess"}, 32'(GUESS), 32'(m_guess));
      chk({tag, " secret"}, 32'(SECRET), 32'(m_secret));
      chk({tag, " tries"}, 32'(TRIES), 32'(m_tries));
      chk({tag, " high"}, 32'(HIGH), 32'(m_high));
      chk({tag, " low"}, 32'(LOW), 32'(m_low));
      chk({tag, " win"}, 32'(WIN), 32'(m_win));
      chk({tag, " lose"}, 32'(LOSE), 32'(m_lose));
      chk({tag, " err"}, 32'(ERR), 32'(m_err));
   endtask

   task automatic model_reset();
      m_guess = 0; m_secret = 0; m_tries = 0; m_on = 0;
      m_high = 0; m_low = 0; m_win = 0; m_lose = 0; m_err = 0;
   endtask

   task automatic do_start(input int target, input bit with_sub, input logic [2:0] sw);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (target < 0 || m_seed == target) break;
      end
      START = 1'b1;
      if (with_sub) begin
         SW = sw;
         SUBMIT = 1'b1;
      end
      m_secret = m_seed; m_tries = 0; m_on = 1;
      m_high = 0; m_low = 0; m_win = 0; m_lose = 0; m_err = 0;
      @(negedge clk);
      START = 1'b0;
      SUBMIT = 1'b0;
      check_all(with_sub ? "restart_sub" : "start");
   endtask

   task automatic do_submit(input logic [2:0] sw, input bit b, input int hold);
      @(negedge clk);
      SW = sw;
      SUBMIT = 1'b1;
      @(negedge clk);
      bad = b;
      @(negedge clk);
      bad = 1'b0;
      if (m_on) begin
         m_guess = sw;
         m_tries++;
         if (b) begin
            m_err = 1; m_lose = 1; m_high = 0; m_low = 0;
         end else if (sw == m_secret) begin
            m_win = 1; m_high = 0; m_low = 0;
         end else begin
            m_high = sw > m_secret;
            m_low = sw < m_secret;
            m_lose = m_tries == MT;
         end
         m_on = !b && sw != m_secret && m_tries < MT;
      end
      check_all(b ? "submit_err" : "submit");
      repeat (hold) @(negedge clk);
      SUBMIT = 1'b0;
      if (hold > 0) check_all("held");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      #1 check_all("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_start(5, 0, 0);
      do_submit(3, 0, 0);
      do_submit(6, 0, 0);
      do_start(5, 0, 0);
      do_submit(5, 0, 0);
      do_submit(2, 0, 0);
      do_start(5, 0, 0);
      repeat (4) do_submit(0, 0, 0);
      do_submit(0, 0, 0);
      do_start(5, 0, 0);
      do_submit(1, 0, 0);
      do_start(-1, 1, 7);
      do_submit(1, 0, 10);
      do_start(5, 0, 0);
      do_submit(5, 1, 0);
      do_start(5, 0, 0);
      do_submit(0, 0, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int g = 0; g < 40; g++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         do_start(-1, 0, 0);
         for (int a = 0; a < 10 && m_on; a++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r == 0) do_start(-1, 1, 3'($urandom_range(0, 7)));
            else do_submit(3'($urandom_range(0, 7)), r == 1, r == 2 ? 3 : 0);
         end
         if ($urandom_range(0, 1) == 1) do_submit(3'($urandom_range(0, 7)), 0, 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
